// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin hopper controller with pending-coin queue, jam timeout and sticky overflow
// Optional coins_paid/stray outputs under CHANGE_DISPENSER_STATS_EN.
module change_dispenser #(
    parameter int PEND_W      = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int GAP_CYC     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       coin_det,
    output logic       hop_en,
    output logic       busy,
    output logic       jam,
    output logic       ovf
`ifdef CHANGE_DISPENSER_STATS_EN
    ,
    output logic [7:0] coins_paid,
    output logic       stray
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [PEND_W+1:0] PMAX = {2'b00, {PEND_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, MOTOR, GAP, JAM} state_t;

    state_t              state;
    logic [PEND_W-1:0]   pending;
    logic [TW-1:0]       tcnt;
    logic [GW-1:0]       gcnt;
    logic                coin_q;
    logic                coin_edge;
    logic                pay;
    logic                bad_code;
    logic [1:0]          add;
    logic [PEND_W+1:0]   sum;

    // Net capture/payout is computed wide so saturation can be detected after the decrement.
    always_comb begin
        coin_edge = coin_det & ~coin_q;
        pay       = (state == MOTOR) & coin_edge;
        bad_code  = vend & (change == 2'd3);
        add       = (vend && change != 2'd3) ? change : 2'd0;
        sum       = {2'b00, pending} + {{PEND_W{1'b0}}, add} - {{(PEND_W+1){1'b0}}, pay};
    end

    assign busy = (state != IDLE) | (pending != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            tcnt    <= '0;
            gcnt    <= '0;
            coin_q  <= 1'b0;
            hop_en  <= 1'b0;
            jam     <= 1'b0;
            ovf     <= 1'b0;
`ifdef CHANGE_DISPENSER_STATS_EN
            coins_paid <= '0;
            stray      <= 1'b0;
`endif
        end else begin
            coin_q <= coin_det;
            if (sum > PMAX) begin
                pending <= PMAX[PEND_W-1:0];
                ovf     <= 1'b1;
            end else begin
                pending <= sum[PEND_W-1:0];
            end
            if (bad_code)
                ovf <= 1'b1;
`ifdef CHANGE_DISPENSER_STATS_EN
            if (pay)
                coins_paid <= coins_paid + 8'd1;
            if (coin_edge && state != MOTOR)
                stray <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        state  <= MOTOR;
                        hop_en <= 1'b1;
                        tcnt   <= '0;
                    end
                end
                MOTOR: begin
                    tcnt <= tcnt + 1'b1;
                    if (coin_edge) begin
                        state  <= GAP;
                        hop_en <= 1'b0;
                        gcnt   <= GW'(GAP_CYC - 1);
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        state  <= JAM;
                        hop_en <= 1'b0;
                        jam    <= 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == '0)
                        state <= IDLE;
                    else
                        gcnt <= gcnt - 1'b1;
                end
                JAM: begin
                    hop_en <= 1'b0;
                    jam    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser against a coin-count model
module tb_change_dispenser;
    localparam int PW = 4;
    localparam int TO = 20;
    localparam int GP = 4;
    localparam int MAXP = (1 << PW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend = 1'b0;
    logic [1:0] change = 2'd0;
    logic       coin_det = 1'b0;
    logic       hop_en, busy, jam, ovf;
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [7:0] coins_paid;
    logic       stray;
`endif

    always #5 clk = ~clk;

    change_dispenser #(.PEND_W(PW), .TIMEOUT_CYC(TO), .GAP_CYC(GP)) dut (
        .clk(clk), .rst(rst), .vend(vend), .change(change), .coin_det(coin_det),
        .hop_en(hop_en), .busy(busy), .jam(jam), .ovf(ovf)
`ifdef CHANGE_DISPENSER_STATS_EN
        , .coins_paid(coins_paid), .stray(stray)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: coins owed, whether the motor is running, cycles run, gap cycles left.
    int m_pend = 0, m_run = 0, m_hold = 0, m_paid = 0;
    bit m_motor = 0, m_jam = 0, m_ovf = 0, m_stray = 0, m_prev_cd = 0;

    task automatic model_step();
        int nxt, dec;
        bit edge_seen;
        if (rst) begin
            m_pend = 0; m_run = 0; m_hold = 0; m_paid = 0;
            m_motor = 0; m_jam = 0; m_ovf = 0; m_stray = 0; m_prev_cd = 0;
            return;
        end
        edge_seen = coin_det && !m_prev_cd;
        m_prev_cd = coin_det;
        dec = (m_motor && edge_seen) ? 1 : 0;
        if (edge_seen && !m_motor) m_stray = 1;
        nxt = m_pend - dec;
        if (vend) begin
            if (change == 2'd1) nxt += 1;
            else if (change == 2'd2) nxt += 2;
            else if (change == 2'd3) m_ovf = 1;
        end
        if (nxt > MAXP) begin
            nxt = MAXP;
            m_ovf = 1;
        end
        if (m_jam) begin
        end else if (m_motor) begin
            if (edge_seen) begin
                m_motor = 0;
                m_hold = GP;
                m_paid = (m_paid + 1) % 256;
            end else begin
                m_run++;
                if (m_run == TO) begin
                    m_motor = 0;
                    m_jam = 1;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_pend != 0) begin
            m_motor = 1;
            m_run = 0;
        end
        m_pend = nxt;
    endtask

    bit hopper_on = 0, h_armed = 0, prev_hop = 0;
    int h_wait = 0, h_left = 0, h_wfix = 0, hop_rises = 0;

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("hop_en", hop_en, m_motor);
        check("busy", busy, (m_motor || m_hold > 0 || m_jam || m_pend != 0));
        check("jam", jam, m_jam);
        check("ovf", ovf, m_ovf);
`ifdef CHANGE_DISPENSER_STATS_EN
        check("coins_paid", coins_paid, m_paid);
        check("stray", stray, m_stray);
`endif
        if (hop_en && !prev_hop) hop_rises++;
        prev_hop = hop_en;
        vend = 0; change = 0; rst = 0;
        if (!m_motor && h_wait == 0 && h_left == 0) h_armed = 0;
        if (!hopper_on) begin
            coin_det = 0;
        end else if (h_left > 0) begin
            coin_det = 1;
            h_left--;
        end else begin
            coin_det = 0;
            if (h_wait > 0) begin
                h_wait--;
                if (h_wait == 0) h_left = (h_wfix != 0) ? h_wfix : $urandom_range(1, 4);
            end else if (m_motor && !h_armed) begin
                h_wait = $urandom_range(1, 5);
                h_armed = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        h_wait = 0; h_left = 0; h_armed = 0;
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            cyc();
            n++;
        end
        check(tag, (n < bound), 1);
    endtask

    task automatic wait_motor(input string tag);
        int n = 0;
        while (!m_motor && n < 20) begin
            cyc();
            n++;
        end
        check(tag, m_motor, 1);
    endtask

    initial begin
        do_reset();
        do_reset();
        check("rst_hop", hop_en, 0);
        check("rst_busy", busy, 0);
        check("rst_jam", jam, 0);
        check("rst_ovf", ovf, 0);

        // Two coins paid out with 3-cycle sensor pulses.
        hopper_on = 1; h_wfix = 3;
        vend = 1; change = 2; cyc();
        check("t1_hop_n", hop_en, 0);
        check("t1_busy_n", busy, 1);
        cyc();
        check("t1_hop_n1", hop_en, 1);
        drain("t1_drain", 200);
`ifdef CHANGE_DISPENSER_STATS_EN
        check("t1_paid", coins_paid, 2);
`endif

        // Jam with no sensor activity.
        do_reset();
        hopper_on = 0;
        vend = 1; change = 1; cyc();
        repeat (TO + 3) cyc();
        check("t2_jam", jam, 1);
        check("t2_hop", hop_en, 0);
        vend = 1; change = 2; cyc();
        repeat (5) cyc();
        check("t2_jam_hold", jam, 1);
        do_reset();
        check("t2_jam_clr", jam, 0);

        // Saturation at 15 then a full drain.
        hop_rises = 0;
        repeat (8) begin
            vend = 1; change = 2; cyc();
        end
        check("t3_ovf", ovf, 1);
        hopper_on = 1; h_wfix = 0;
        drain("t3_drain", 800);
        check("t3_rounds", hop_rises, 15);

        // Reserved code.
        do_reset();
        vend = 1; change = 3; cyc();
        check("t4_ovf", ovf, 1);
        check("t4_busy", busy, 0);
        cyc();
        check("t4_busy2", busy, 0);

        // Capture coinciding with a confirmed coin.
        do_reset();
        hopper_on = 0;
        vend = 1; change = 1; cyc();
        wait_motor("t5_motor");
        hop_rises = 0;
        coin_det = 1; vend = 1; change = 2; cyc();
        check("t5_gap_hop", hop_en, 0);
        hopper_on = 1; h_wfix = 2;
        drain("t5_drain", 200);
        check("t5_rounds", hop_rises, 2);

        // Sensor pulse while idle.
        do_reset();
        hopper_on = 0;
        coin_det = 1; cyc();
        cyc();
        check("t6_busy", busy, 0);
        check("t6_hop", hop_en, 0);

        // Reset while the motor runs with three coins owed.
        do_reset();
        vend = 1; change = 2; cyc();
        vend = 1; change = 1; cyc();
        wait_motor("t7_motor");
        rst = 1; cyc();
        check("t7_hop", hop_en, 0);
        check("t7_busy", busy, 0);
        repeat (4) cyc();
        check("t7_idle", busy, 0);

        // Randomized traffic.
        h_wfix = 0;
        for (int i = 0; i < 1500; i++) begin
            hopper_on = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 299) == 0) rst = 1;
            if ($urandom_range(0, 5) == 0) begin
                vend = 1;
                change = 2'($urandom_range(0, 3));
            end
            if (!hopper_on && $urandom_range(0, 9) == 0) begin
                cyc();
                coin_det = 1;
            end else begin
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
